// File: rtl/sig_control_timed_if.sv
// Sensor and lamp signals of one highway/country intersection controller.
interface sig_control_timed_if;
   logic       X;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic [2:0] phase;

   modport master (output X, input hwy, input cntry, input phase);
   modport slave  (input X, output hwy, output cntry, output phase);
endinterface

// File: rtl/sig_control_timed.sv
// Highway/country-road signal controller with dwell counters and a synchronised sensor.
// Optional country-green timeout is enabled by defining SIG_CTRL_MAXGREEN_EN.
module sig_control_timed #(
   parameter int unsigned Y2R_DELAY       = 3,
   parameter int unsigned R2G_DELAY       = 2,
   parameter int unsigned MIN_HWY_GREEN   = 4,
   parameter int unsigned MAX_CNTRY_GREEN = 8,
   parameter int unsigned TIMER_WIDTH     = 4,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input logic               clock,
   input logic               clear_n,
   sig_control_timed_if.slave sig
);

   typedef enum logic [2:0] {
      StHg = 3'd0,
      StHy = 3'd1,
      StAr = 3'd2,
      StCg = 3'd3,
      StCy = 3'd4
   } state_e;

   localparam logic [1:0] LampRed    = 2'd0;
   localparam logic [1:0] LampYellow = 2'd1;
   localparam logic [1:0] LampGreen  = 2'd2;

`ifdef SIG_CTRL_MAXGREEN_EN
   localparam bit MaxGreenEn = 1'b1;
`else
   localparam bit MaxGreenEn = 1'b0;
`endif

   localparam logic [TIMER_WIDTH-1:0] CntMax  = '1;
   localparam logic [TIMER_WIDTH-1:0] HgLast  = TIMER_WIDTH'(MIN_HWY_GREEN - 1);
   localparam logic [TIMER_WIDTH-1:0] Y2rLast = TIMER_WIDTH'(Y2R_DELAY - 1);
   localparam logic [TIMER_WIDTH-1:0] R2gLast = TIMER_WIDTH'(R2G_DELAY - 1);
   localparam logic [TIMER_WIDTH-1:0] CgLast  = TIMER_WIDTH'(MAX_CNTRY_GREEN - 1);

   // The register is plain logic so codes 5-7 remain representable and recoverable.
   logic [2:0]             state_q;
   state_e                 state_d;
   logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   x_sync;
   logic                   cg_timeout;

   assign x_sync     = sync_q[SYNC_STAGES-1];
   assign cg_timeout = MaxGreenEn && (cnt_q == CgLast);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         sync_q  <= '0;
         state_q <= StHg;
         cnt_q   <= '0;
         req_q   <= 1'b0;
      end else begin
         sync_q  <= (sync_q << 1) | SYNC_STAGES'(sig.X);
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = StHg;
      req_d   = req_q;
      unique case (state_q)
         StHg: begin
            state_d = StHg;
            if ((req_q || x_sync) && (cnt_q >= HgLast)) begin
               state_d = StHy;
               req_d   = 1'b0;
            end else if (x_sync) begin
               req_d = 1'b1;
            end
         end
         StHy: state_d = (cnt_q == Y2rLast) ? StAr : StHy;
         StAr: state_d = (cnt_q == R2gLast) ? StCg : StAr;
         StCg: state_d = (!x_sync || cg_timeout) ? StCy : StCg;
         StCy: state_d = (cnt_q == Y2rLast) ? StHg : StCy;
         default: state_d = StHg;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      sig.hwy   = LampGreen;
      sig.cntry = LampRed;
      sig.phase = state_q;
      unique case (state_q)
         StHg: ;
         StHy: sig.hwy = LampYellow;
         StAr: sig.hwy = LampRed;
         StCg: begin
            sig.hwy   = LampRed;
            sig.cntry = LampGreen;
         end
         StCy: begin
            sig.hwy   = LampRed;
            sig.cntry = LampYellow;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sig_control_timed.sv
// Randomised and directed bench for sig_control_timed against a time-in-state reference model.
module tb_sig_control_timed;

   localparam int Y2R   = 3;
   localparam int R2G   = 2;
   localparam int MINHG = 4;
   localparam int MAXCG = 8;
   localparam int SYNC  = 2;
`ifdef SIG_CTRL_MAXGREEN_EN
   localparam bit MaxgEn = 1'b1;
`else
   localparam bit MaxgEn = 1'b0;
`endif

   logic clock = 1'b0;
   logic clear_n;

   sig_control_timed_if sig ();

   sig_control_timed #(
      .Y2R_DELAY       (Y2R),
      .R2G_DELAY       (R2G),
      .MIN_HWY_GREEN   (MINHG),
      .MAX_CNTRY_GREEN (MAXCG),
      .TIMER_WIDTH     (4),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .sig     (sig)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: phase code, cycles already displayed, request flag, sensor delay line.
   int m_phase;
   int m_time;
   bit m_req;
   bit xq[$];

   function automatic void model_reset();
      m_phase = 0;
      m_time  = 0;
      m_req   = 1'b0;
      xq.delete();
      for (int i = 0; i < SYNC; i++) xq.push_back(1'b0);
   endfunction

   function automatic void model_step(input bit x);
      bit xs;
      int held;
      int nxt;
      xs = xq.pop_front();
      xq.push_back(x);
      held = m_time + 1;
      nxt  = m_phase;
      case (m_phase)
         0: if ((m_req || xs) && held >= MINHG) nxt = 1;
         1: if (held == Y2R) nxt = 2;
         2: if (held == R2G) nxt = 3;
         3: if (!xs || (MaxgEn && held == MAXCG)) nxt = 4;
         4: if (held == Y2R) nxt = 0;
         default: nxt = 0;
      endcase
      if (m_phase == 0) m_req = (nxt == 1) ? 1'b0 : (m_req | xs);
      m_time  = (nxt != m_phase) ? 0 : m_time + 1;
      m_phase = nxt;
   endfunction

   function automatic int hwy_of(input int p);
      case (p)
         1:       return 1;
         2, 3, 4: return 0;
         default: return 2;
      endcase
   endfunction

   function automatic int cntry_of(input int p);
      case (p)
         3:       return 2;
         4:       return 1;
         default: return 0;
      endcase
   endfunction

   task automatic compare_all(input string tag);
      check({tag, "_phase"}, int'(sig.phase), m_phase);
      check({tag, "_hwy"}, int'(sig.hwy), hwy_of(m_phase));
      check({tag, "_cntry"}, int'(sig.cntry), cntry_of(m_phase));
      check({tag, "_overlap"}, int'(sig.hwy != 2'd0 && sig.cntry != 2'd0), 0);
   endtask

   // One rising edge, then compare on the falling edge.
   task automatic tick();
      @(posedge clock);
      if (clear_n) model_step(sig.X);
      else model_reset();
      @(negedge clock);
      compare_all("cyc");
   endtask

   // Reset pulse between edges; outputs must change with no clock edge.
   task automatic pulse_reset();
      #2;
      clear_n = 1'b0;
      model_reset();
      #1;
      compare_all("async_rst");
      #1;
      clear_n = 1'b1;
   endtask

   int exp_basic [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 3, 3};
   int exp_rel   [6]  = '{3, 3, 4, 4, 4, 0};
   int exp_short [14] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 4, 4, 0, 0};

   initial begin
      clear_n = 1'b0;
      sig.X   = 1'b0;
      model_reset();
      #1;
      compare_all("reset");
      @(negedge clock);
      clear_n = 1'b1;

      // Basic cycle with X held high.
      sig.X = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("basic_e%0d", i + 1), int'(sig.phase), exp_basic[i]);
      end

      // Async reset while in country green.
      pulse_reset();
      check("rst_in_cg_phase", int'(sig.phase), 0);

      // Back to CG, then release the country road.
      for (int i = 0; i < 20 && m_phase != 3; i++) tick();
      check("reach_cg", int'(sig.phase), 3);
      sig.X = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("release_k%0d", i), int'(sig.phase), exp_rel[i]);
      end

      // Single-cycle sensor pulse must still be served.
      pulse_reset();
      sig.X = 1'b1;
      tick();
      check("short_e1", int'(sig.phase), exp_short[0]);
      sig.X = 1'b0;
      for (int i = 1; i < 14; i++) begin
         tick();
         check($sformatf("short_e%0d", i + 1), int'(sig.phase), exp_short[i]);
      end

      // Country request held high for a long time.
      pulse_reset();
      sig.X = 1'b1;
      for (int i = 0; i < 60; i++) tick();
`ifndef SIG_CTRL_MAXGREEN_EN
      check("cg_held", int'(sig.phase), 3);
`endif

      // Illegal state code recovers to highway green.
      sig.X = 1'b0;
      pulse_reset();
      tick();
      force dut.state_q = 3'd6;
      #1;
      check("illegal_phase", int'(sig.phase), 6);
      check("illegal_hwy", int'(sig.hwy), 2);
      check("illegal_cntry", int'(sig.cntry), 0);
      release dut.state_q;
      tick();
      check("illegal_recover", int'(sig.phase), 0);
      pulse_reset();

      // Random sensor traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) sig.X = ~sig.X;
         if ($urandom_range(0, 149) == 0) pulse_reset();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
